// File: rtl/dct_pkg.sv
// dct_pkg: shared widths and sequencer state encoding for the 4-point DCT row path
package dct_pkg;
    localparam int WIDTH_X = 9;
    localparam int WIDTH_Y = 17;
    localparam int DCT_N = 4;
    localparam int ROW_W = $clog2(DCT_N);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
endpackage

// File: rtl/dct_row_fifo.sv
// dct_row_fifo: synchronous FIFO with occupancy count; data output reads zero when empty
module dct_row_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rp, wp;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else if (clr) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= inc(wp);
            if (pop) rp <= inc(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    assign dout = count != '0 ? mem[rp] : '0;
endmodule

// File: rtl/dct4_row_sequencer.sv
// dct4_row_sequencer: issues rows into the non-stallable bloque under a credit limit
// and collects its results, tagged with the row index, in a local FIFO.
module dct4_row_sequencer
    import dct_pkg::*;
#(
    parameter int WIDTH_X = dct_pkg::WIDTH_X,
    parameter int WIDTH_Y = dct_pkg::WIDTH_Y,
    parameter int LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     abort,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DCT_N*WIDTH_X-1:0] s_x,
    output logic                     blk_rst,
    output logic                     blk_load,
    output logic [WIDTH_X-1:0]       blk_x0,
    output logic [WIDTH_X-1:0]       blk_x1,
    output logic [WIDTH_X-1:0]       blk_x2,
    output logic [WIDTH_X-1:0]       blk_x3,
    input  logic [WIDTH_Y-1:0]       blk_y0,
    input  logic [WIDTH_Y-1:0]       blk_y1,
    input  logic [WIDTH_Y-1:0]       blk_y2,
    input  logic [WIDTH_Y-1:0]       blk_y3,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DCT_N*WIDTH_Y-1:0] m_y,
    output logic [ROW_W-1:0]         m_row,
    output logic                     m_last,
    output logic                     busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(LATENCY + 1);
    state_t state, state_nx;
    logic up, accept;
    logic [ROW_W-1:0] row_cnt, row_nx, tag;
    logic [FW-1:0] fcnt;
    logic [LATENCY-1:0] tv, tv_nx;
    logic [LATENCY:0] tv_cat;
    logic [ROW_W-1:0] tr [LATENCY];
    logic [CW-1:0] fifo_count;
    assign tv_cat = {tv, blk_load};
    assign tv_nx = tv_cat[LATENCY-1:0];
    // every row between issue and FIFO exit holds a credit, so the FIFO can never overflow
    always_comb begin
        s_ready = up & (state != FLUSH) & ~abort
                & (32'(fifo_count) + 32'($countones(tv)) + 32'(blk_load) < 32'(FIFO_DEPTH));
        accept = s_valid & s_ready;
        row_nx = row_cnt + ROW_W'(accept);
        state_nx = abort ? FLUSH
                 : state == FLUSH ? (fcnt == '0 ? IDLE : FLUSH)
                 : (row_nx == '0 && !accept && tv_nx == '0) ? IDLE : RUN;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            up <= 1'b0;
            blk_rst <= 1'b1;
            blk_load <= 1'b0;
            row_cnt <= '0;
            tag <= '0;
            fcnt <= '0;
            tv <= '0;
            {blk_x3, blk_x2, blk_x1, blk_x0} <= '0;
        end else begin
            state <= state_nx;
            up <= up | ~blk_rst;
            blk_rst <= state_nx == FLUSH;
            blk_load <= accept;
            row_cnt <= abort ? '0 : row_nx;
            tv <= abort ? '0 : tv_nx;
            fcnt <= abort ? FW'(LATENCY) : fcnt - FW'(state == FLUSH && fcnt != '0);
            if (accept) begin
                tag <= row_cnt;
                {blk_x3, blk_x2, blk_x1, blk_x0} <= s_x;
            end
        end
    always_ff @(posedge clk) begin
        tr[0] <= tag;
        for (int i = 1; i < LATENCY; i++) tr[i] <= tr[i-1];
    end
    dct_row_fifo #(.W(DCT_N*WIDTH_Y + ROW_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk,
        .rst,
        .clr(abort),
        .push(tv[LATENCY-1]),
        .pop(m_valid & m_ready),
        .din({blk_y3, blk_y2, blk_y1, blk_y0, tr[LATENCY-1]}),
        .dout({m_y, m_row}),
        .count(fifo_count)
    );
    assign m_valid = fifo_count != '0;
    assign m_last = m_row == ROW_W'(DCT_N - 1);
    assign busy = state != IDLE;
endmodule

// File: tb/tb_dct4_row_sequencer.sv
// tb_dct4_row_sequencer: directed and random rows against a bloque stub and a row-queue reference
module tb_dct4_row_sequencer;
    localparam int WX = 9;
    localparam int WY = 17;
    localparam int LAT = 2;
    localparam int DEP = 4;
    logic clk = 0, rst = 0, abort = 0, s_valid = 0, m_ready = 1;
    logic [4*WX-1:0] s_x = '0;
    logic s_ready, blk_rst, blk_load, m_valid, m_last, busy;
    logic [WX-1:0] blk_x0, blk_x1, blk_x2, blk_x3;
    logic [WY-1:0] blk_y0, blk_y1, blk_y2, blk_y3;
    logic [4*WY-1:0] m_y;
    logic [1:0] m_row;
    int total = 0, bad = 0, nacc = 0, nout = 0;
    int base, outbase, last, c;
    logic [4*WY+1:0] q[$];
    logic [4*WY+1:0] e;
    logic [1:0] mrow = 0;
    logic [4*WY-1:0] stg [LAT];

    always #5 clk = ~clk;

    dct4_row_sequencer #(.WIDTH_X(WX), .WIDTH_Y(WY), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .abort(abort), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
        .blk_rst(blk_rst), .blk_load(blk_load),
        .blk_x0(blk_x0), .blk_x1(blk_x1), .blk_x2(blk_x2), .blk_x3(blk_x3),
        .blk_y0(blk_y0), .blk_y1(blk_y1), .blk_y2(blk_y2), .blk_y3(blk_y3),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_row(m_row), .m_last(m_last), .busy(busy)
    );

    function automatic logic [WY-1:0] sx(input logic [WX-1:0] v);
        return {{(WY-WX){v[WX-1]}}, v};
    endfunction
    function automatic logic [4*WY-1:0] widen(input logic [4*WX-1:0] x);
        return {sx(x[4*WX-1:3*WX]), sx(x[3*WX-1:2*WX]), sx(x[2*WX-1:WX]), sx(x[WX-1:0])};
    endfunction
    function automatic logic [4*WX-1:0] rnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[4*WX-1:0];
    endfunction

    // bloque stub: sign-extended lanes appear LAT edges after the load sample
    always @(posedge clk) begin
        if (blk_rst) for (int i = 0; i < LAT; i++) stg[i] <= '0;
        else begin
            stg[0] <= blk_load ? widen({blk_x3, blk_x2, blk_x1, blk_x0}) : '0;
            for (int j = 1; j < LAT; j++) stg[j] <= stg[j-1];
        end
    end
    assign {blk_y3, blk_y2, blk_y1, blk_y0} = blk_rst ? '0 : stg[LAT-1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: accepted rows queue in order, aborts and resets discard everything pending
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mrow = 0;
        end else begin
            if (m_valid && m_ready) begin
                if (q.size() == 0) chk("unexpected_out", m_valid, 1'b0);
                else begin
                    e = q.pop_front();
                    chk("out_y", m_y, e[4*WY+1:2]);
                    chk("out_row", m_row, e[1:0]);
                    chk("out_last", m_last, e[1:0] == 2'd3);
                    nout++;
                end
            end
            if (abort) begin
                chk("ready_abort", s_ready, 1'b0);
                q.delete();
                mrow = 0;
            end else if (s_valid && s_ready) begin
                q.push_back({widen(s_x), mrow});
                mrow++;
                nacc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push_row(input logic [4*WX-1:0] x);
        int ok;
        ok = 0;
        s_valid = 1;
        s_x = x;
        for (int i = 0; i < 64 && ok == 0; i++) begin
            @(negedge clk);
            ok = int'(s_ready);
        end
        tick();
        s_valid = 0;
        chk("push_accept", ok, 1);
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("drain_empty", q.size(), 0);
        chk("drain_mvalid", m_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_blk_rst", blk_rst, 1'b1);
        chk("rst_blk_load", blk_load, 1'b0);
        chk("rst_blk_x", {blk_x3, blk_x2, blk_x1, blk_x0}, 36'h0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_y", m_y, 68'h0);
        chk("rst_m_row", m_row, 2'd0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1;
        tick();
        chk("rel_blk_rst", blk_rst, 1'b0);
        chk("rel_ready1", s_ready, 1'b0);
        tick();
        chk("rel_ready2", s_ready, 1'b1);

        push_row({4{9'h100}});
        chk("lat_1", m_valid, 1'b0);
        push_row({4{9'h001}});
        chk("lat_2", m_valid, 1'b0);
        push_row({4{9'h100}});
        chk("lat_3", m_valid, 1'b0);
        push_row({4{9'h001}});
        chk("lat_4", m_valid, 1'b1);
        chk("first_lane0", m_y[WY-1:0], 17'h1FF00);
        chk("first_row", m_row, 2'd0);
        repeat (2) tick();
        chk("busy_before_last_push", busy, 1'b1);
        tick();
        chk("busy_after_last_push", busy, 1'b0);
        chk("last_row", m_row, 2'd3);
        chk("last_flag", m_last, 1'b1);
        chk("last_lane0", m_y[WY-1:0], 17'h00001);
        drain();

        m_ready = 0;
        base = nacc;
        outbase = nout;
        s_valid = 1;
        s_x = rnd();
        repeat (12) begin
            last = nacc;
            tick();
            if (nacc != last) s_x = rnd();
        end
        chk("bp_accepted", nacc - base, 4);
        chk("bp_ready", s_ready, 1'b0);
        chk("bp_mvalid", m_valid, 1'b1);
        m_ready = 1;
        c = 0;
        while (nacc - base < 8 && c < 100) begin
            last = nacc;
            tick();
            c++;
            if (nacc != last) s_x = rnd();
        end
        s_valid = 0;
        chk("bp_total", nacc - base, 8);
        drain();
        chk("bp_out", nout - outbase, 8);

        outbase = nout;
        push_row(rnd());
        push_row(rnd());
        abort = 1;
        s_valid = 1;
        s_x = rnd();
        tick();
        abort = 0;
        s_valid = 0;
        for (int k = 0; k < LAT + 1; k++) begin
            chk("ab_blk_rst", blk_rst, 1'b1);
            chk("ab_ready", s_ready, 1'b0);
            chk("ab_mvalid", m_valid, 1'b0);
            tick();
        end
        chk("ab_blk_rst_end", blk_rst, 1'b0);
        chk("ab_ready_end", s_ready, 1'b1);
        push_row(rnd());
        drain();
        chk("ab_out", nout - outbase, 1);

        base = nacc;
        outbase = nout;
        m_ready = 1;
        s_valid = 1;
        s_x = rnd();
        c = 0;
        while (nacc - base < 20 && c < 200) begin
            last = nacc;
            tick();
            c++;
            if (nacc != last) s_x = rnd();
        end
        s_valid = 0;
        drain();
        chk("stream_out", nout - outbase, 20);

        repeat (150) begin
            abort = ($urandom_range(0, 39) == 0);
            s_valid = $urandom_range(0, 1) == 1;
            m_ready = $urandom_range(0, 2) != 0;
            s_x = rnd();
            tick();
        end
        abort = 0;
        s_valid = 0;
        m_ready = 1;
        drain();

        m_ready = 0;
        push_row(rnd());
        push_row(rnd());
        repeat (4) tick();
        chk("ar_pre_mvalid", m_valid, 1'b1);
        #2 rst = 0;
        #1;
        chk("ar_mvalid", m_valid, 1'b0);
        chk("ar_ready", s_ready, 1'b0);
        chk("ar_blk_rst", blk_rst, 1'b1);
        chk("ar_busy", busy, 1'b0);
        tick();
        tick();
        rst = 1;
        m_ready = 1;
        repeat (10) begin
            tick();
            chk("ar_no_stale", m_valid, 1'b0);
        end
        outbase = nout;
        push_row(rnd());
        drain();
        chk("ar_out", nout - outbase, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
